// File: rtl/minesweeper_ctrl.sv
// Sequential game controller for the combinational minesweeper board: owns the bomb, reveal
// and cursor grids and sequences cursor moves, reveals, zero-square flood fill and win/loss.
module minesweeper_ctrl #(
  parameter int GRID_SIZE  = 3,
  parameter int STATE_SIZE = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      btnNew,
  input  logic                                      btnReveal,
  input  logic                                      btnMove,
  input  logic [1:0]                                btnDir,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]            bombPattern,
  input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]            nextCursorGrid,
  output logic [GRID_SIZE*GRID_SIZE-1:0]            bombGrid,
  output logic [GRID_SIZE*GRID_SIZE-1:0]            revealGrid,
  output logic [GRID_SIZE*GRID_SIZE-1:0]            cursorGrid,
  output logic                                      move,
  output logic [1:0]                                dir,
  output logic [2:0]                                gameState,
  output logic                                      busy,
  output logic                                      won,
  output logic                                      lost
);

  localparam int N = GRID_SIZE * GRID_SIZE;
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] TOP_LEFT = ONE << (N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    MOVE   = 3'd2,
    REVEAL = 3'd3,
    FLOOD  = 3'd4,
    CHECK  = 3'd5,
    WON    = 3'd6,
    LOST   = 3'd7
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   bomb_grid_reg;
  logic [N-1:0]   reveal_grid_reg;
  logic [N-1:0]   cursor_grid_reg;
  logic           move_reg;
  logic [1:0]     dir_reg;
  logic           busy_reg;
  logic           won_reg;
  logic           lost_reg;
  logic           new_prev_reg;
  logic           reveal_prev_reg;
  logic           move_prev_reg;

  logic           new_pulse;
  logic           reveal_pulse;
  logic           move_pulse;
  logic           in_busy;
  logic [N-1:0]   square_zero;
  logic [N-1:0]   zero_open;
  logic [N-1:0]   grow;
  logic           cursor_bomb;
  logic           cursor_zero;
  logic           all_clear;

  // 8-neighbourhood of one square, clipped at the board edges (no wrap-around).
  function automatic logic [N-1:0] neighbour_mask(input int idx);
    logic [N-1:0] m;
    int r;
    int c;
    m = '0;
    r = idx / GRID_SIZE;
    c = idx % GRID_SIZE;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) &&
            (r + dr >= 0) && (r + dr < GRID_SIZE) &&
            (c + dc >= 0) && (c + dc < GRID_SIZE)) begin
          m = m | (ONE << ((r + dr) * GRID_SIZE + (c + dc)));
        end
      end
    end
    return m;
  endfunction

  assign new_pulse    = btnNew    & ~new_prev_reg;
  assign reveal_pulse = btnReveal & ~reveal_prev_reg;
  assign move_pulse   = btnMove   & ~move_prev_reg;

  assign in_busy = (state_reg == MOVE) || (state_reg == REVEAL) ||
                   (state_reg == FLOOD) || (state_reg == CHECK);

  // A square grows the flood when it is hidden, safe, and touches an opened zero square.
  for (genvar gi = 0; gi < N; gi++) begin : g_square
    localparam logic [N-1:0] NBR = neighbour_mask(gi);
    assign square_zero[gi] = (states[gi*STATE_SIZE +: STATE_SIZE] == '0);
    assign zero_open[gi]   = square_zero[gi] & reveal_grid_reg[gi] & ~bomb_grid_reg[gi];
    assign grow[gi]        = (|(zero_open & NBR)) & ~reveal_grid_reg[gi] & ~bomb_grid_reg[gi];
  end

  assign cursor_bomb = |(cursor_grid_reg & bomb_grid_reg);
  assign cursor_zero = |(cursor_grid_reg & square_zero);
  assign all_clear   = &(reveal_grid_reg | bomb_grid_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, WON, LOST: begin
        if (new_pulse) state_next = PLAY;
      end
      PLAY: begin
        if (new_pulse)         state_next = PLAY;
        else if (reveal_pulse) state_next = REVEAL;
        else if (move_pulse)   state_next = MOVE;
      end
      MOVE:   state_next = PLAY;
      REVEAL: begin
        if (cursor_bomb)      state_next = LOST;
        else if (cursor_zero) state_next = FLOOD;
        else                  state_next = CHECK;
      end
      FLOOD: begin
        if (grow == '0) state_next = CHECK;
      end
      CHECK:   state_next = all_clear ? WON : PLAY;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      bomb_grid_reg   <= '0;
      reveal_grid_reg <= '0;
      cursor_grid_reg <= TOP_LEFT;
      move_reg        <= 1'b0;
      dir_reg         <= 2'b00;
      busy_reg        <= 1'b0;
      won_reg         <= 1'b0;
      lost_reg        <= 1'b0;
      new_prev_reg    <= 1'b0;
      reveal_prev_reg <= 1'b0;
      move_prev_reg   <= 1'b0;
    end else begin
      new_prev_reg    <= btnNew;
      reveal_prev_reg <= btnReveal;
      move_prev_reg   <= btnMove;

      state_reg <= state_next;
      move_reg  <= (state_next == MOVE);
      busy_reg  <= (state_next == MOVE) || (state_next == REVEAL) ||
                   (state_next == FLOOD) || (state_next == CHECK);
      won_reg   <= (state_next == WON);
      lost_reg  <= (state_next == LOST);

      if (state_next == MOVE) dir_reg <= btnDir;

      // A new-game press outranks everything else whenever the FSM is not mid-sequence.
      if (new_pulse && !in_busy) begin
        bomb_grid_reg   <= bombPattern;
        reveal_grid_reg <= '0;
        cursor_grid_reg <= TOP_LEFT;
      end else begin
        case (state_reg)
          MOVE: begin
            if (|nextCursorGrid) cursor_grid_reg <= nextCursorGrid;
          end
          REVEAL:  reveal_grid_reg <= reveal_grid_reg | cursor_grid_reg;
          FLOOD:   reveal_grid_reg <= reveal_grid_reg | grow;
          LOST:    reveal_grid_reg <= '1;
          default: ;
        endcase
      end
    end
  end

  assign bombGrid   = bomb_grid_reg;
  assign revealGrid = reveal_grid_reg;
  assign cursorGrid = cursor_grid_reg;
  assign move       = move_reg;
  assign dir        = dir_reg;
  assign gameState  = state_reg;
  assign busy       = busy_reg;
  assign won        = won_reg;
  assign lost       = lost_reg;

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// Bench for minesweeper_ctrl: behavioural board, scripted vector table, multi-cycle corner
// sequences and random play checked against a transaction-level game model.
module tb_minesweeper_ctrl;

  localparam int G  = 3;
  localparam int SS = 4;
  localparam int N  = G * G;
  localparam logic [N-1:0] ONE = 9'h001;

  localparam int OP_NEW  = 0;
  localparam int OP_MOVE = 1;
  localparam int OP_REV  = 2;
  localparam int OP_BOTH = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            btnNew, btnReveal, btnMove;
  logic [1:0]      btnDir;
  logic [N-1:0]    bombPattern;
  logic [SS*N-1:0] states;
  logic [N-1:0]    nextCursorGrid;
  logic [N-1:0]    bombGrid, revealGrid, cursorGrid;
  logic            move;
  logic [1:0]      dir;
  logic [2:0]      gameState;
  logic            busy, won, lost;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  minesweeper_ctrl #(.GRID_SIZE(G), .STATE_SIZE(SS)) dut (
    .clk(clk), .reset(reset), .btnNew(btnNew), .btnReveal(btnReveal), .btnMove(btnMove),
    .btnDir(btnDir), .bombPattern(bombPattern), .states(states), .nextCursorGrid(nextCursorGrid),
    .bombGrid(bombGrid), .revealGrid(revealGrid), .cursorGrid(cursorGrid), .move(move),
    .dir(dir), .gameState(gameState), .busy(busy), .won(won), .lost(lost)
  );

  function automatic bit bit_at(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic int adj_count(input logic [N-1:0] b, input int r, input int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < G && c + dc >= 0 && c + dc < G)
          if (bit_at(b, (r + dr) * G + c + dc)) n++;
    return n;
  endfunction

  // Board direction rules: right/left move toward lower/higher column, up/down toward higher/lower row.
  function automatic logic [N-1:0] shift_cursor(input logic [N-1:0] cur, input logic [1:0] d);
    int k = -1;
    int r, c;
    for (int i = 0; i < N; i++) if (bit_at(cur, i)) k = i;
    if (k < 0) return '0;
    r = k / G;
    c = k % G;
    case (d)
      2'b00:   if (c > 0) c--;
      2'b01:   if (r < G - 1) r++;
      2'b10:   if (c < G - 1) c++;
      default: if (r > 0) r--;
    endcase
    return ONE << (r * G + c);
  endfunction

  // Behavioural combinational board.
  always_comb begin
    states = '0;
    for (int i = 0; i < N; i++) begin
      if (bit_at(bombGrid, i)) states[i*SS +: SS] = 4'd9;
      else                     states[i*SS +: SS] = 4'(adj_count(bombGrid, i / G, i % G));
    end
    nextCursorGrid = move ? shift_cursor(cursorGrid, dir) : cursorGrid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Press the requested buttons for one edge, then wait for the sequence to settle.
  task automatic do_op(input int op, input logic [1:0] d, input logic [N-1:0] pat,
                       output int busy_cnt, output int move_cnt, output bit timed_out);
    @(negedge clk);
    btnNew      = (op == OP_NEW);
    btnReveal   = (op == OP_REV) || (op == OP_BOTH);
    btnMove     = (op == OP_MOVE) || (op == OP_BOTH);
    btnDir      = d;
    bombPattern = pat;
    @(negedge clk);
    btnNew = 1'b0; btnReveal = 1'b0; btnMove = 1'b0;
    busy_cnt = 0;
    move_cnt = 0;
    while (busy && busy_cnt < 4 * N + 8) begin
      busy_cnt++;
      if (move) move_cnt++;
      @(negedge clk);
    end
    timed_out = busy;
    repeat (2) begin
      if (move) move_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_all(input string tag, input int st, input logic [N-1:0] cur,
                           input logic [N-1:0] rev, input logic [N-1:0] bomb,
                           input int exp_b, input int exp_m, input int got_b, input int got_m,
                           input bit to);
    chk({tag, " timeout"}, 32'(to), 32'd0);
    chk({tag, " gameState"}, 32'(gameState), 32'(st));
    chk({tag, " cursorGrid"}, 32'(cursorGrid), 32'(cur));
    chk({tag, " revealGrid"}, 32'(revealGrid), 32'(rev));
    chk({tag, " bombGrid"}, 32'(bombGrid), 32'(bomb));
    chk({tag, " won"}, 32'(won), 32'(st == 6));
    chk({tag, " lost"}, 32'(lost), 32'(st == 7));
    chk({tag, " busy_cycles"}, 32'(got_b), 32'(exp_b));
    chk({tag, " move_cycles"}, 32'(got_m), 32'(exp_m));
    $display("%s: state=%0d cursor=%h reveal=%h bomb=%h busy_cycles=%0d",
             tag, gameState, cursorGrid, revealGrid, bombGrid, got_b);
  endtask

  // Transaction-level game model: row/column cursor, breadth-first flood.
  int           m_state = 0;
  logic [N-1:0] m_bomb  = '0;
  logic [N-1:0] m_rev   = '0;
  int           m_r = G - 1, m_c = G - 1;
  int           m_busy, m_moves;

  task automatic model_op(input int op, input logic [1:0] d, input logic [N-1:0] pat);
    int idx, rings, k;
    int q[$];
    int nq[$];
    m_busy = 0;
    m_moves = 0;
    if (op == OP_NEW) begin
      m_bomb = pat; m_rev = '0; m_r = G - 1; m_c = G - 1; m_state = 1;
      return;
    end
    if (m_state != 1) return;
    if (op == OP_MOVE) begin
      m_busy = 1; m_moves = 1;
      case (d)
        2'b00:   if (m_c > 0) m_c--;
        2'b01:   if (m_r < G - 1) m_r++;
        2'b10:   if (m_c < G - 1) m_c++;
        default: if (m_r > 0) m_r--;
      endcase
      return;
    end
    idx = m_r * G + m_c;
    m_rev = m_rev | (ONE << idx);
    if (bit_at(m_bomb, idx)) begin
      m_state = 7; m_rev = '1; m_busy = 1;
      return;
    end
    if (adj_count(m_bomb, m_r, m_c) == 0) begin
      rings = 0;
      q.push_back(idx);
      while (q.size() > 0) begin
        nq = {};
        foreach (q[j]) begin
          if (adj_count(m_bomb, q[j] / G, q[j] % G) == 0) begin
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                int rr = q[j] / G + dr;
                int cc = q[j] % G + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < G && cc >= 0 && cc < G) begin
                  k = rr * G + cc;
                  if (!bit_at(m_rev, k) && !bit_at(m_bomb, k)) begin
                    m_rev = m_rev | (ONE << k);
                    nq.push_back(k);
                  end
                end
              end
          end
        end
        if (nq.size() > 0) rings++;
        q = nq;
      end
      m_busy = rings + 3;
    end else begin
      m_busy = 2;
    end
    m_state = ((m_rev | m_bomb) == '1) ? 6 : 1;
  endtask

  typedef struct {
    int           op;
    logic [1:0]   d;
    logic [N-1:0] pat;
    int           st;
    logic [N-1:0] cur, rev, bomb;
    int           busy_n, moves_n;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int op, input logic [1:0] d, input logic [N-1:0] pat, input int st,
                     input logic [N-1:0] cur, input logic [N-1:0] rev, input logic [N-1:0] bomb,
                     input int b, input int m);
    vec_t v;
    v.op = op; v.d = d; v.pat = pat; v.st = st; v.cur = cur; v.rev = rev; v.bomb = bomb;
    v.busy_n = b; v.moves_n = m;
    vecs.push_back(v);
  endtask

  initial begin
    int bc, mc, cnt;
    bit to;
    reset = 1'b1; btnNew = 1'b0; btnReveal = 1'b0; btnMove = 1'b0;
    btnDir = 2'b00; bombPattern = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset gameState", 32'(gameState), 32'd0);
    chk("reset cursorGrid", 32'(cursorGrid), 32'h100);
    chk("reset revealGrid", 32'(revealGrid), 32'h0);
    chk("reset bombGrid", 32'(bombGrid), 32'h0);
    chk("reset move", 32'(move), 32'd0);
    chk("reset dir", 32'(dir), 32'd0);
    chk("reset busy/won/lost", 32'({busy, won, lost}), 32'd0);

    //   op       dir    pattern  st  cursor  reveal  bomb   busy moves
    add(OP_REV,  2'b00, 9'h000, 0, 9'h100, 9'h000, 9'h000, 0, 0);
    add(OP_MOVE, 2'b00, 9'h000, 0, 9'h100, 9'h000, 9'h000, 0, 0);
    add(OP_NEW,  2'b00, 9'h001, 1, 9'h100, 9'h000, 9'h001, 0, 0);
    add(OP_MOVE, 2'b00, 9'h001, 1, 9'h080, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b10, 9'h001, 1, 9'h100, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b10, 9'h001, 1, 9'h100, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b01, 9'h001, 1, 9'h100, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b11, 9'h001, 1, 9'h020, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b11, 9'h001, 1, 9'h004, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b11, 9'h001, 1, 9'h004, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b00, 9'h001, 1, 9'h002, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b00, 9'h001, 1, 9'h001, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b00, 9'h001, 1, 9'h001, 9'h000, 9'h001, 1, 1);
    add(OP_MOVE, 2'b10, 9'h001, 1, 9'h002, 9'h000, 9'h001, 1, 1);
    add(OP_REV,  2'b00, 9'h001, 1, 9'h002, 9'h002, 9'h001, 2, 0);
    add(OP_REV,  2'b00, 9'h001, 1, 9'h002, 9'h002, 9'h001, 2, 0);
    add(OP_BOTH, 2'b01, 9'h001, 1, 9'h002, 9'h002, 9'h001, 2, 0);
    add(OP_MOVE, 2'b01, 9'h001, 1, 9'h010, 9'h002, 9'h001, 1, 1);
    add(OP_REV,  2'b00, 9'h001, 1, 9'h010, 9'h012, 9'h001, 2, 0);
    add(OP_MOVE, 2'b01, 9'h001, 1, 9'h080, 9'h012, 9'h001, 1, 1);
    add(OP_REV,  2'b00, 9'h001, 6, 9'h080, 9'h1FE, 9'h001, 5, 0);
    add(OP_MOVE, 2'b00, 9'h001, 6, 9'h080, 9'h1FE, 9'h001, 0, 0);
    add(OP_REV,  2'b00, 9'h001, 6, 9'h080, 9'h1FE, 9'h001, 0, 0);
    add(OP_NEW,  2'b00, 9'h001, 1, 9'h100, 9'h000, 9'h001, 0, 0);
    add(OP_REV,  2'b00, 9'h001, 6, 9'h100, 9'h1FE, 9'h001, 5, 0);
    add(OP_NEW,  2'b00, 9'h100, 1, 9'h100, 9'h000, 9'h100, 0, 0);
    add(OP_REV,  2'b00, 9'h100, 7, 9'h100, 9'h1FF, 9'h100, 1, 0);
    add(OP_MOVE, 2'b00, 9'h100, 7, 9'h100, 9'h1FF, 9'h100, 0, 0);
    add(OP_NEW,  2'b00, 9'h010, 1, 9'h100, 9'h000, 9'h010, 0, 0);
    add(OP_REV,  2'b00, 9'h010, 1, 9'h100, 9'h100, 9'h010, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].d, vecs[i].pat, bc, mc, to);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cur, vecs[i].rev, vecs[i].bomb,
                vecs[i].busy_n, vecs[i].moves_n, bc, mc, to);
    end

    // Bomb reveal: lost right after the REVEAL cycle, whole board shown one edge later.
    do_op(OP_NEW, 2'b00, 9'h100, bc, mc, to);
    @(negedge clk); btnReveal = 1'b1;
    @(negedge clk); btnReveal = 1'b0;
    chk("bomb E0 gameState", 32'(gameState), 32'd3);
    chk("bomb E0 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("bomb E1 gameState", 32'(gameState), 32'd7);
    chk("bomb E1 lost", 32'(lost), 32'd1);
    chk("bomb E1 revealGrid", 32'(revealGrid), 32'h100);
    @(negedge clk);
    chk("bomb E2 revealGrid", 32'(revealGrid), 32'h1FF);
    $display("seq bomb: state=%0d reveal=%h", gameState, revealGrid);

    // New game ignored mid-flood, then reset mid-flood.
    do_op(OP_NEW, 2'b00, 9'h001, bc, mc, to);
    @(negedge clk); btnReveal = 1'b1;
    @(negedge clk); btnReveal = 1'b0;
    chk("flood E0 gameState", 32'(gameState), 32'd3);
    @(negedge clk);
    chk("flood E1 gameState", 32'(gameState), 32'd4);
    chk("flood E1 revealGrid", 32'(revealGrid), 32'h100);
    btnNew = 1'b1; bombPattern = 9'h0F0;
    @(negedge clk);
    chk("flood E2 gameState", 32'(gameState), 32'd4);
    chk("flood E2 revealGrid", 32'(revealGrid), 32'h1B0);
    chk("flood E2 bombGrid", 32'(bombGrid), 32'h001);
    reset = 1'b1; btnNew = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("flood reset gameState", 32'(gameState), 32'd0);
    chk("flood reset revealGrid", 32'(revealGrid), 32'h0);
    chk("flood reset bombGrid", 32'(bombGrid), 32'h0);
    chk("flood reset cursorGrid", 32'(cursorGrid), 32'h100);
    chk("flood reset busy", 32'(busy), 32'd0);
    $display("seq flood/reset: state=%0d reveal=%h", gameState, revealGrid);

    // A held move button yields a single move.
    do_op(OP_NEW, 2'b00, 9'h000, bc, mc, to);
    @(negedge clk); btnMove = 1'b1; btnDir = 2'b00;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (move) cnt++;
    end
    btnMove = 1'b0;
    @(negedge clk);
    chk("held move_cycles", 32'(cnt), 32'd1);
    chk("held cursorGrid", 32'(cursorGrid), 32'h080);
    $display("seq held: moves=%0d cursor=%h", cnt, cursorGrid);

    // Reset during MOVE leaves no partial cursor update.
    @(negedge clk); btnMove = 1'b1; btnDir = 2'b11;
    @(negedge clk); btnMove = 1'b0;
    chk("movereset E0 gameState", 32'(gameState), 32'd2);
    chk("movereset E0 move", 32'(move), 32'd1);
    chk("movereset E0 dir", 32'(dir), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("movereset gameState", 32'(gameState), 32'd0);
    chk("movereset cursorGrid", 32'(cursorGrid), 32'h100);
    chk("movereset move", 32'(move), 32'd0);
    chk("movereset dir", 32'(dir), 32'd0);
    $display("seq move/reset: state=%0d cursor=%h", gameState, cursorGrid);

    // Random play against the game model.
    for (int t = 0; t < 300; t++) begin
      int unsigned r;
      int op;
      logic [1:0] d;
      logic [N-1:0] pat;
      r = $urandom_range(0, 99);
      if (t == 0 || r < 8) op = OP_NEW;
      else if (r < 50)     op = OP_MOVE;
      else if (r < 92)     op = OP_REV;
      else                 op = OP_BOTH;
      d = 2'($urandom_range(0, 3));
      pat = 9'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) pat = '0;
      model_op(op, d, pat);
      do_op(op, d, pat, bc, mc, to);
      check_all($sformatf("rnd%0d op%0d", t, op), m_state, ONE << (m_r * G + m_c), m_rev, m_bomb,
                m_busy, m_moves, bc, mc, to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
